// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oled_pkg
//  Description : Shared constants and FSM state type for the OLED text frame
//                sequencer. Holds the display geometry, the three per-page
//                command bytes and the sequencer state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package oled_pkg;

    localparam int OLED_PAGES = 4;   // 8 pixel rows per page
    localparam int OLED_COLS  = 16;  // character cells per page
    localparam int GLYPH_W    = 8;   // glyph columns per cell

    localparam int PAGE_W = 2;       // page index width
    localparam int COL_W  = 4;       // column index width
    localparam int CELL_W = 6;       // page*COLS+col

    localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO    = 8'h00;
    localparam logic [7:0] CMD_COL_HI    = 8'h10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_LOAD = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/oled_text_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : oled_text_frame_sequencer_if
//  Description : Byte stream towards the SPI byte transmitter.
//                tx_byte  - byte offered
//                tx_cmd   - 1 = command byte (D/C low), 0 = display data
//                tx_valid - byte offered this cycle
//                tx_ready - transmitter accepts when tx_valid && tx_ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface oled_text_frame_sequencer_if;
    logic [7:0] tx_byte;
    logic       tx_cmd;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_byte, output tx_cmd, output tx_valid, input tx_ready);
    modport slave  (input tx_byte, input tx_cmd, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/oled_glyph_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : oled_glyph_serializer
//  Description : Holds one 64-bit glyph word and presents its 8 column bytes
//                in order, leftmost column (MSB byte) first.
//                clk, rst_n   - clock, synchronous active-low reset
//                load         - capture word, restart at byte 0
//                advance      - current byte accepted, step to next byte
//                invert       - bit-invert the presented byte
//                word         - glyph word from the character ROM
//                glyph_byte   - current column byte
//                last         - current byte is column 7
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_glyph_serializer
    import oled_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        load,
    input  wire logic        advance,
    input  wire logic        invert,
    input  wire logic [63:0] word,
    output logic      [7:0]  glyph_byte,
    output logic             last
);

    logic [63:0] glyph_q, glyph_d;
    logic [2:0]  idx_q,   idx_d;
    logic [5:0]  w_base;

    always_comb begin
        glyph_d = glyph_q;
        idx_d   = idx_q;
        if (load) begin
            glyph_d = word;
            idx_d   = 3'd0;
        end else if (advance) begin
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            glyph_q <= '0;
            idx_q   <= '0;
        end else begin
            glyph_q <= glyph_d;
            idx_q   <= idx_d;
        end
    end

    // Byte k sits at bits [63-8k -: 8]; its low bit index is 8*(7-k) = {~k,3'b0}.
    assign w_base     = {~idx_q, 3'b000};
    assign glyph_byte = glyph_q[w_base +: 8] ^ {8{invert}};
    assign last       = (idx_q == 3'(GLYPH_W - 1));

endmodule
`default_nettype wire

// File: rtl/oled_text_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : oled_text_frame_sequencer
//  Description : Refreshes a 128x32 OLED from a 4x16 ASCII text buffer, one
//                full frame per accepted start. Per page: 3 command bytes,
//                then for each cell: read code, address ROM, stream 8 bytes.
//                clk, rst_n  - clock, synchronous active-low reset
//                start       - frame request (IDLE only)
//                invert      - latched at start, inverts all data bytes
//                busy, done  - frame in progress / end-of-frame pulse
//                cell_addr   - text buffer address, cell_code its data
//                rom_addr    - char ROM address, rom_data its glyph word
//                tx          - byte stream to SPI transmitter (master)
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_text_frame_sequencer
    import oled_pkg::*;
(
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    start,
    input  wire logic                    invert,
    output logic                         busy,
    output logic                         done,
    output logic [CELL_W-1:0]            cell_addr,
    input  wire logic [6:0]              cell_code,
    output logic [6:0]                   rom_addr,
    input  wire logic [63:0]             rom_data,
    oled_text_frame_sequencer_if.master  tx
);

    state_e              state_q,    state_d;
    logic [PAGE_W-1:0]   page_q,     page_d;
    logic [COL_W-1:0]    col_q,      col_d;
    logic [1:0]          cmd_idx_q,  cmd_idx_d;
    logic                inv_q,      inv_d;
    logic [6:0]          rom_addr_q, rom_addr_d;

    logic       ser_load;
    logic       ser_adv;
    logic [7:0] ser_byte;
    logic       ser_last;
    logic       w_accept;

    assign w_accept = tx.tx_valid && tx.tx_ready;

    oled_glyph_serializer u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ser_load),
        .advance    (ser_adv),
        .invert     (inv_q),
        .word       (rom_data),
        .glyph_byte (ser_byte),
        .last       (ser_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            page_q     <= '0;
            col_q      <= '0;
            cmd_idx_q  <= '0;
            inv_q      <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            col_q      <= col_d;
            cmd_idx_q  <= cmd_idx_d;
            inv_q      <= inv_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        col_d       = col_q;
        cmd_idx_d   = cmd_idx_q;
        inv_d       = inv_q;
        rom_addr_d  = rom_addr_q;
        ser_load    = 1'b0;
        ser_adv     = 1'b0;
        tx.tx_valid = 1'b0;
        tx.tx_cmd   = 1'b0;
        tx.tx_byte  = 8'h00;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    inv_d     = invert;
                    page_d    = '0;
                    col_d     = '0;
                    cmd_idx_d = '0;
                    state_d   = S_CMD;
                end
            end

            S_CMD: begin
                tx.tx_valid = 1'b1;
                tx.tx_cmd   = 1'b1;
                case (cmd_idx_q)
                    2'd0:    tx.tx_byte = CMD_PAGE_BASE | {{(8-PAGE_W){1'b0}}, page_q};
                    2'd1:    tx.tx_byte = CMD_COL_LO;
                    default: tx.tx_byte = CMD_COL_HI;
                endcase
                if (w_accept) begin
                    if (cmd_idx_q == 2'd2) begin
                        cmd_idx_d = '0;
                        state_d   = S_ADDR;
                    end else begin
                        cmd_idx_d = cmd_idx_q + 2'd1;
                    end
                end
            end

            S_ADDR: begin
                rom_addr_d = cell_code;
                state_d    = S_LOAD;
            end

            S_LOAD: begin
                ser_load = 1'b1;
                state_d  = S_DATA;
            end

            S_DATA: begin
                tx.tx_valid = 1'b1;
                tx.tx_byte  = ser_byte;
                if (w_accept) begin
                    ser_adv = 1'b1;
                    if (ser_last) begin
                        if (col_q != COL_W'(OLED_COLS - 1)) begin
                            col_d   = col_q + 4'd1;
                            state_d = S_ADDR;
                        end else if (page_q != PAGE_W'(OLED_PAGES - 1)) begin
                            col_d   = '0;
                            page_d  = page_q + 2'd1;
                            state_d = S_CMD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cell_addr = {page_q, col_q};
    assign rom_addr  = rom_addr_q;
    assign busy      = (state_q == S_CMD) || (state_q == S_ADDR) ||
                       (state_q == S_LOAD) || (state_q == S_DATA);
    assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_oled_text_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oled_text_frame_sequencer
//  Description : Scoreboard bench for oled_text_frame_sequencer. Stimulus
//                pushes expected {cmd,byte} pairs; a negedge monitor pops and
//                compares each accepted byte and checks hold stability.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_text_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        invert = 1'b0;
    logic        busy, done;
    logic [5:0]  cell_addr;
    logic [6:0]  cell_code;
    logic [6:0]  rom_addr;
    logic [63:0] rom_data;

    logic [6:0]  tbuf [64];
    logic [8:0]  sb [$];

    int n_cmp = 0;
    int n_err = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    bit rnd_ready = 1'b0;

    bit         prev_hold = 1'b0;
    logic [8:0] prev_tx   = '0;

    oled_text_frame_sequencer_if tx_if ();

    oled_text_frame_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .invert    (invert),
        .busy      (busy),
        .done      (done),
        .cell_addr (cell_addr),
        .cell_code (cell_code),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .tx        (tx_if.master)
    );

    always #5 clk = ~clk;

    // Hand-tabulated glyphs for the characters used by the tests.
    function automatic logic [63:0] glyph(input logic [6:0] code);
        case (code)
            7'h41:   glyph = 64'h407C4A094A7C4000;  // 'A'
            7'h43:   glyph = 64'h1C22414141412200;  // 'C'
            7'h20:   glyph = 64'h0000000000000000;  // ' '
            default: glyph = {8{1'b0, code}};
        endcase
    endfunction

    assign cell_code = tbuf[cell_addr];
    assign rom_data  = glyph(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // tx_ready driver: changes just after the rising edge.
    always @(posedge clk) begin
        #1;
        tx_if.tx_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // Monitor: sampled on the falling edge, reflecting what the next rising edge sees.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", {31'd0, tx_if.tx_valid}, 32'd1);
                chk("hold_bytecmd", {23'd0, tx_if.tx_cmd, tx_if.tx_byte}, {23'd0, prev_tx});
            end
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                xfer_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_byte", {23'd0, tx_if.tx_cmd, tx_if.tx_byte}, 32'h1FF);
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    chk($sformatf("xfer%0d", xfer_cnt), {23'd0, tx_if.tx_cmd, tx_if.tx_byte}, {23'd0, e});
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_in_done", {31'd0, busy}, 32'd0);
            end
            prev_hold = tx_if.tx_valid && !tx_if.tx_ready;
            prev_tx   = {tx_if.tx_cmd, tx_if.tx_byte};
        end
    end

    task automatic fill(input logic [6:0] code);
        for (int i = 0; i < 64; i++) tbuf[i] = code;
    endtask

    task automatic build_expected(input bit inv);
        logic [63:0] g;
        for (int p = 0; p < 4; p++) begin
            sb.push_back({1'b1, 8'hB0 | 8'(p)});
            sb.push_back({1'b1, 8'h00});
            sb.push_back({1'b1, 8'h10});
            for (int c = 0; c < 16; c++) begin
                g = glyph(tbuf[p*16 + c]);
                for (int k = 0; k < 8; k++)
                    sb.push_back({1'b0, g[63 - 8*k -: 8] ^ {8{inv}}});
            end
        end
    endtask

    task automatic launch(input bit inv);
        sb.delete();
        build_expected(inv);
        xfer_cnt = 0;
        done_cnt = 0;
        @(posedge clk); #2;
        invert = inv;
        start  = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_frame(input string tag, input bit inv, input bit toggle, input bit extra);
        int cyc;
        bit saw_done;
        bit used100;
        launch(inv);
        cyc = 0; saw_done = 0; used100 = 0;
        while (!saw_done && cyc < 10000) begin
            @(posedge clk); #2;
            cyc++;
            start = 1'b0;
            if (toggle && xfer_cnt >= 50) invert = ~inv;
            if (extra && !used100 && xfer_cnt >= 100) begin
                start = 1'b1;
                used100 = 1'b1;
            end
            if (done) begin
                saw_done = 1'b1;
                if (extra) start = 1'b1;
            end
        end
        if (!saw_done) chk({tag, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #2;
        start  = 1'b0;
        invert = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_xfers"}, 32'(xfer_cnt), 32'd524);
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        tx_if.tx_ready = 1'b1;
        fill(7'h41);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, tx_if.tx_valid}, 32'd0);
        chk("rst_cmd", {31'd0, tx_if.tx_cmd}, 32'd0);
        chk("rst_byte", {24'd0, tx_if.tx_byte}, 32'd0);
        chk("rst_cell_addr", {26'd0, cell_addr}, 32'd0);
        chk("rst_rom_addr", {25'd0, rom_addr}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: all 'A', ready always high, no inversion
        run_frame("t1", 1'b0, 1'b0, 1'b0);

        // 2: blank screen with 'C' in the last cell
        fill(7'h20);
        tbuf[63] = 7'h43;
        run_frame("t2", 1'b0, 1'b0, 1'b0);

        // 3: all 'A' with back-pressure
        fill(7'h41);
        rnd_ready = 1'b1;
        run_frame("t3", 1'b0, 1'b0, 1'b0);
        rnd_ready = 1'b0;

        // 4: inverted frame, invert toggled mid-frame
        run_frame("t4", 1'b1, 1'b1, 1'b0);

        // 5: start while busy and during DONE
        run_frame("t5", 1'b0, 1'b0, 1'b1);

        // 6: reset mid-frame, then a clean frame
        begin
            int cyc;
            launch(1'b0);
            cyc = 0;
            while (xfer_cnt < 200 && cyc < 5000) begin
                @(posedge clk); #2;
                cyc++;
            end
            chk("t6_reach200", {31'd0, xfer_cnt >= 200}, 32'd1);
            rst_n = 1'b0;
            @(posedge clk); #2;
            chk("t6_rst_valid", {31'd0, tx_if.tx_valid}, 32'd0);
            chk("t6_rst_busy", {31'd0, busy}, 32'd0);
            rst_n = 1'b1;
            sb.delete();
            repeat (2) @(posedge clk);
            run_frame("t6", 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
